cdb_arbiter: RTL and testbench

Round-robin arbiter that shares the single common data bus (CDB) among N functional units. Each unit posts a completed result (tag, data, ROB id) into a private one-entry holding buffer. The arbiter grants one buffered result per cycle and drives it onto a registered CDB broadcast. Reservation stations, the register-status logic and the ROB consume that broadcast.

---
 rtl/cdb_arbiter_if.sv | 28 ++
 rtl/cdb_arbiter.sv | 141 ++++++++++++++
 tb/tb_cdb_arbiter.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_if.sv
// Functional-unit result inputs and CDB broadcast outputs of cdb_arbiter.
// The master side is the FU/consumer cluster; the slave side is the arbiter.
interface cdb_arbiter_if #(
    parameter int N_REQ     = 4,
    parameter int TAG_W     = 4,
    parameter int ROB_PTR_W = 4
);
    logic [N_REQ-1:0]           fu_req;
    logic [N_REQ*TAG_W-1:0]     fu_tag;
    logic [N_REQ*32-1:0]        fu_wdata;
    logic [N_REQ*ROB_PTR_W-1:0] fu_inst_id;
    logic [N_REQ-1:0]           fu_rdy;
    logic                       cdb_wr;
    logic [TAG_W-1:0]           cdb_tag;
    logic [31:0]                cdb_wdata;
    logic [ROB_PTR_W-1:0]       cdb_inst_id;
    logic                       err_tag0;

    modport master (
        output fu_req, fu_tag, fu_wdata, fu_inst_id,
        input  fu_rdy, cdb_wr, cdb_tag, cdb_wdata, cdb_inst_id, err_tag0
    );

    modport slave (
        input  fu_req, fu_tag, fu_wdata, fu_inst_id,
        output fu_rdy, cdb_wr, cdb_tag, cdb_wdata, cdb_inst_id, err_tag0
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: one-entry holding buffer per functional unit,
// one registered broadcast per cycle.

module cdb_arbiter_lane #(
    parameter int TAG_W     = 4,
    parameter int ROB_PTR_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_i,
    input  logic                 grant_i,
    input  logic [TAG_W-1:0]     tag_i,
    input  logic [31:0]          wdata_i,
    input  logic [ROB_PTR_W-1:0] id_i,
    output logic                 rdy_o,
    output logic                 vld_o,
    output logic                 tag0_o,
    output logic [TAG_W-1:0]     tag_o,
    output logic [31:0]          wdata_o,
    output logic [ROB_PTR_W-1:0] id_o
);
    logic                 vld_q, vld_d;
    logic [TAG_W-1:0]     tag_q;
    logic [31:0]          wdata_q;
    logic [ROB_PTR_W-1:0] id_q;
    logic                 accept, load;

    // A granted buffer frees up in the same cycle, so it can refill back-to-back.
    assign rdy_o  = ~vld_q | grant_i;
    assign accept = req_i & rdy_o;
    assign load   = accept & (tag_i != '0);
    assign tag0_o = accept & (tag_i == '0);

    always_comb begin
        vld_d = vld_q;
        if (load)         vld_d = 1'b1;
        else if (grant_i) vld_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) vld_q <= 1'b0;
        else     vld_q <= vld_d;
        if (load) begin
            tag_q   <= tag_i;
            wdata_q <= wdata_i;
            id_q    <= id_i;
        end
    end

    assign vld_o   = vld_q;
    assign tag_o   = tag_q;
    assign wdata_o = wdata_q;
    assign id_o    = id_q;
endmodule

module cdb_arbiter #(
    parameter int N_REQ     = 4,
    parameter int TAG_W     = 4,
    parameter int ROB_PTR_W = 4
) (
    input  logic       clk,
    input  logic       rst,
    cdb_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(N_REQ);

    logic [N_REQ-1:0]                buf_vld, grant, tag0;
    logic [N_REQ-1:0][TAG_W-1:0]     buf_tag;
    logic [N_REQ-1:0][31:0]          buf_wdata;
    logic [N_REQ-1:0][ROB_PTR_W-1:0] buf_id;

    logic [PTR_W-1:0]     rr_q, rr_d, gidx;
    logic                 found;
    logic [PTR_W:0]       scan;
    logic                 cdb_wr_q;
    logic [TAG_W-1:0]     cdb_tag_q;
    logic [31:0]          cdb_wdata_q;
    logic [ROB_PTR_W-1:0] cdb_id_q;
    logic                 err_q;

    for (genvar i = 0; i < N_REQ; i++) begin : g_lane
        cdb_arbiter_lane #(.TAG_W(TAG_W), .ROB_PTR_W(ROB_PTR_W)) u_lane (
            .clk     (clk),
            .rst     (rst),
            .req_i   (bus.fu_req[i]),
            .grant_i (grant[i]),
            .tag_i   (bus.fu_tag[i*TAG_W +: TAG_W]),
            .wdata_i (bus.fu_wdata[i*32 +: 32]),
            .id_i    (bus.fu_inst_id[i*ROB_PTR_W +: ROB_PTR_W]),
            .rdy_o   (bus.fu_rdy[i]),
            .vld_o   (buf_vld[i]),
            .tag0_o  (tag0[i]),
            .tag_o   (buf_tag[i]),
            .wdata_o (buf_wdata[i]),
            .id_o    (buf_id[i])
        );
    end

    // Scan from rr_q upward with explicit wrap so non-power-of-2 N_REQ works.
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        scan  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan = {1'b0, rr_q} + (PTR_W+1)'(k);
            if (scan >= (PTR_W+1)'(N_REQ)) scan = scan - (PTR_W+1)'(N_REQ);
            if (!found && buf_vld[scan[PTR_W-1:0]]) begin
                found = 1'b1;
                gidx  = scan[PTR_W-1:0];
            end
        end
        grant = found ? (N_REQ'(1) << gidx) : '0;
        rr_d  = (gidx == PTR_W'(N_REQ-1)) ? '0 : gidx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q        <= '0;
            cdb_wr_q    <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_wdata_q <= '0;
            cdb_id_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            cdb_wr_q <= found;
            if (found) begin
                rr_q        <= rr_d;
                cdb_tag_q   <= buf_tag[gidx];
                cdb_wdata_q <= buf_wdata[gidx];
                cdb_id_q    <= buf_id[gidx];
            end
            if (|tag0) err_q <= 1'b1;
        end
    end

    assign bus.cdb_wr      = cdb_wr_q;
    assign bus.cdb_tag     = cdb_tag_q;
    assign bus.cdb_wdata   = cdb_wdata_q;
    assign bus.cdb_inst_id = cdb_id_q;
    assign bus.err_tag0    = err_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: a 4-requester and a 3-requester instance share one
// stimulus stream and are each tracked against a cycle-level reference model.
module tb_cdb_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [3:0]       req;
    logic [3:0][3:0]  tag;
    logic [3:0][31:0] wdata;
    logic [3:0][3:0]  id;

    cdb_arbiter_if #(.N_REQ(4), .TAG_W(4), .ROB_PTR_W(4)) if4 ();
    cdb_arbiter_if #(.N_REQ(3), .TAG_W(4), .ROB_PTR_W(4)) if3 ();

    assign if4.fu_req     = req;
    assign if4.fu_tag     = tag;
    assign if4.fu_wdata   = wdata;
    assign if4.fu_inst_id = id;
    assign if3.fu_req     = req[2:0];
    assign if3.fu_tag     = tag[2:0];
    assign if3.fu_wdata   = wdata[2:0];
    assign if3.fu_inst_id = id[2:0];

    cdb_arbiter #(.N_REQ(4), .TAG_W(4), .ROB_PTR_W(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
    cdb_arbiter #(.N_REQ(3), .TAG_W(4), .ROB_PTR_W(4)) dut3 (.clk(clk), .rst(rst), .bus(if3.slave));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string t, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", t, got, exp, $time);
        end
    endtask

    // Reference model: index 0 tracks the 4-requester DUT, index 1 the 3-requester one.
    int          n [2] = '{4, 3};
    logic        mvld [2][4];
    logic [3:0]  mtag [2][4];
    logic [31:0] mdat [2][4];
    logic [3:0]  mid  [2][4];
    int          mrr  [2];
    logic        mwr  [2];
    logic [3:0]  mctag[2];
    logic [31:0] mcdat[2];
    logic [3:0]  mcid [2];
    logic        merr [2];
    int          gsel [2];
    logic [3:0]  ardy [2];

    task automatic model_reset(input int d);
        for (int i = 0; i < 4; i++) mvld[d][i] = 1'b0;
        mrr[d] = 0; mwr[d] = 1'b0; mctag[d] = '0; mcdat[d] = '0; mcid[d] = '0; merr[d] = 1'b0;
    endtask

    // One clock: check ready before the edge, advance the model, check the CDB after it.
    task automatic step();
        for (int d = 0; d < 2; d++) begin
            int g;
            int i;
            logic [3:0] r;
            g = -1;
            for (int k = 0; k < n[d]; k++) begin
                i = (mrr[d] + k) % n[d];
                if (g < 0 && mvld[d][i]) g = i;
            end
            r = '0;
            for (int j = 0; j < n[d]; j++) r[j] = !mvld[d][j] || (g == j);
            gsel[d] = g;
            ardy[d] = r;
            if (!rst) chk(d == 0 ? "rdy4" : "rdy3", 64'(d == 0 ? if4.fu_rdy : {1'b0, if3.fu_rdy}), 64'(r));
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            int g;
            if (rst) model_reset(d);
            else begin
                g = gsel[d];
                if (g >= 0) begin
                    mwr[d] = 1'b1; mctag[d] = mtag[d][g]; mcdat[d] = mdat[d][g]; mcid[d] = mid[d][g];
                    mvld[d][g] = 1'b0;
                    mrr[d] = (g + 1) % n[d];
                end else mwr[d] = 1'b0;
                for (int j = 0; j < n[d]; j++) begin
                    if (req[j] && ardy[d][j]) begin
                        if (tag[j] == 4'd0) merr[d] = 1'b1;
                        else begin
                            mvld[d][j] = 1'b1; mtag[d][j] = tag[j]; mdat[d][j] = wdata[j]; mid[d][j] = id[j];
                        end
                    end
                end
            end
        end
        chk("wr4",   64'(if4.cdb_wr),      64'(mwr[0]));
        chk("tag4",  64'(if4.cdb_tag),     64'(mctag[0]));
        chk("data4", 64'(if4.cdb_wdata),   64'(mcdat[0]));
        chk("id4",   64'(if4.cdb_inst_id), 64'(mcid[0]));
        chk("err4",  64'(if4.err_tag0),    64'(merr[0]));
        chk("wr3",   64'(if3.cdb_wr),      64'(mwr[1]));
        chk("tag3",  64'(if3.cdb_tag),     64'(mctag[1]));
        chk("data3", 64'(if3.cdb_wdata),   64'(mcdat[1]));
        chk("id3",   64'(if3.cdb_inst_id), 64'(mcid[1]));
        chk("err3",  64'(if3.err_tag0),    64'(merr[1]));
    endtask

    task automatic do_reset(input int cyc);
        req = '0;
        rst = 1'b1;
        repeat (cyc) step();
        rst = 1'b0;
    endtask

    initial begin
        int t0, seen, acc_c;
        logic acc3, low0;
        rst = 1'b1;
        req = '1;
        for (int i = 0; i < 4; i++) begin
            tag[i] = 4'(i + 1); wdata[i] = 32'(i); id[i] = 4'(i);
        end
        model_reset(0);
        model_reset(1);

        // Reset with every requester asserting: nothing may be captured.
        repeat (2) step();
        rst = 1'b0;
        req = '0;
        chk("rst_wr", 64'(if4.cdb_wr), 64'd0);
        chk("rst_err", 64'(if4.err_tag0), 64'd0);
        chk("rst_rdy", 64'(if4.fu_rdy), 64'hF);
        step();
        chk("rst_nocap", 64'(if4.cdb_wr), 64'd0);

        // Single result from requester 2.
        req[2] = 1'b1; tag[2] = 4'd3; wdata[2] = 32'hDEADBEEF; id[2] = 4'd5;
        step();
        req = '0;
        step();
        chk("single_wr", 64'(if4.cdb_wr), 64'd1);
        chk("single_tag", 64'(if4.cdb_tag), 64'd3);
        chk("single_data", 64'(if4.cdb_wdata), 64'hDEADBEEF);
        chk("single_id", 64'(if4.cdb_inst_id), 64'd5);
        step();
        chk("single_drop", 64'(if4.cdb_wr), 64'd0);

        // Round-robin from a fresh pointer, then a second wave.
        do_reset(1);
        req = '1;
        for (int i = 0; i < 4; i++) begin
            tag[i] = 4'(i + 1); wdata[i] = 32'h100 + 32'(i); id[i] = 4'(i + 8);
        end
        step();
        req = '0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rr_order", 64'(if4.cdb_tag), 64'(k + 1));
            chk("rr_cont", 64'(if4.cdb_wr), 64'd1);
        end
        req = '1;
        for (int i = 0; i < 4; i++) tag[i] = 4'(i + 5);
        step();
        req = '0;
        step();
        chk("rr_wave2", 64'(if4.cdb_tag), 64'd5);
        repeat (4) step();

        // Fairness: requester 0 streams, requester 3 offers once.
        do_reset(1);
        acc3 = 1'b0; low0 = 1'b0; seen = -1; acc_c = -1; t0 = 1;
        for (int c = 0; c < 10; c++) begin
            req[0] = 1'b1; tag[0] = 4'(t0); wdata[0] = 32'(c); id[0] = 4'd1;
            req[3] = (c >= 1) && !acc3; tag[3] = 4'd15; wdata[3] = 32'h33; id[3] = 4'd3;
            step();
            if (!ardy[0][0]) low0 = 1'b1;
            else t0 = (t0 == 14) ? 1 : t0 + 1;
            if (req[3] && ardy[0][3]) begin acc3 = 1'b1; acc_c = c; end
            if (seen < 0 && if4.cdb_wr && if4.cdb_tag == 4'd15) seen = c;
        end
        req = '0;
        chk("fair_lat", 64'(seen >= 0 && acc_c >= 0 && seen - acc_c <= 4), 64'd1);
        chk("fair_rdy0_low", 64'(low0), 64'd1);
        repeat (3) step();

        // Back-to-back results from requester 1.
        do_reset(1);
        for (int k = 1; k <= 3; k++) begin
            req[1] = 1'b1; tag[1] = 4'(k); wdata[1] = 32'h200 + 32'(k); id[1] = 4'(k);
            chk("b2b_rdy", 64'(if4.fu_rdy[1]), 64'd1);
            step();
            if (k > 1) begin
                chk("b2b_tag", 64'(if4.cdb_tag), 64'(k - 1));
                chk("b2b_wr", 64'(if4.cdb_wr), 64'd1);
            end
        end
        req = '0;
        step();
        chk("b2b_tag", 64'(if4.cdb_tag), 64'd3);
        chk("b2b_wr", 64'(if4.cdb_wr), 64'd1);
        step();

        // Tag 0 is consumed, flagged, never broadcast.
        req[0] = 1'b1; tag[0] = 4'd0; wdata[0] = 32'h5A5A; id[0] = 4'd2;
        step();
        req = '0;
        step();
        chk("tag0_nowr", 64'(if4.cdb_wr), 64'd0);
        chk("tag0_err", 64'(if4.err_tag0), 64'd1);
        repeat (3) step();
        chk("tag0_sticky", 64'(if4.err_tag0), 64'd1);

        // Three-requester pointer wrap: after granting 2 the scan restarts at 0.
        do_reset(1);
        chk("err_clr", 64'(if4.err_tag0), 64'd0);
        req[2] = 1'b1; tag[2] = 4'd7;
        step();
        req = '0;
        step();
        chk("wrap_first", 64'(if3.cdb_tag), 64'd7);
        req[0] = 1'b1; tag[0] = 4'd10; req[1] = 1'b1; tag[1] = 4'd11;
        step();
        req = '0;
        step();
        chk("wrap_to0", 64'(if3.cdb_tag), 64'd10);
        step();
        chk("wrap_next", 64'(if3.cdb_tag), 64'd11);

        // Random traffic honouring the hold-while-not-ready handshake.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!(req[i] && !ardy[0][i])) begin
                    req[i]   = ($urandom_range(0, 99) < 60);
                    tag[i]   = ($urandom_range(0, 99) < 3) ? 4'd0 : 4'($urandom_range(1, 15));
                    wdata[i] = $urandom;
                    id[i]    = 4'($urandom_range(0, 15));
                end
            end
            rst = ($urandom_range(0, 99) == 0);
            step();
            rst = 1'b0;
        end
        do_reset(1);
        chk("final_err", 64'(if4.err_tag0), 64'd0);
        chk("final_wr", 64'(if4.cdb_wr), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
